// File: rtl/_register_univ.sv
// Parametrised universal register: hold, load, logical/arithmetic shifts, rotates and clear,
// with a registered shift-out bit and combinational complement and zero flag.
module _register_univ #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             so,
  output logic             z
);

  localparam int M = WIDTH - 1;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  logic [WIDTH-1:0] r_q;
  logic             r_so;
  logic [WIDTH-1:0] w_q_next;
  logic             w_so_next;

  always_comb begin
    w_q_next  = r_q;
    w_so_next = r_so;
    case (op)
      OP_HOLD: begin
        w_q_next  = r_q;
        w_so_next = r_so;
      end
      OP_LOAD: begin
        w_q_next  = d;
        w_so_next = 1'b0;
      end
      OP_SHL: begin
        w_q_next  = {r_q[M-1:0], si};
        w_so_next = r_q[M];
      end
      OP_SHR: begin
        w_q_next  = {si, r_q[M:1]};
        w_so_next = r_q[0];
      end
      OP_ROL: begin
        w_q_next  = {r_q[M-1:0], r_q[M]};
        w_so_next = r_q[M];
      end
      OP_ROR: begin
        w_q_next  = {r_q[0], r_q[M:1]};
        w_so_next = r_q[0];
      end
      // Sign bit is replicated, so repeated ASRs saturate to all copies of q[M].
      OP_ASR: begin
        w_q_next  = {r_q[M], r_q[M:1]};
        w_so_next = r_q[0];
      end
      OP_CLR: begin
        w_q_next  = '0;
        w_so_next = 1'b0;
      end
      default: begin
        w_q_next  = r_q;
        w_so_next = r_so;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q  <= '0;
      r_so <= 1'b0;
    end else if (en) begin
      r_q  <= w_q_next;
      r_so <= w_so_next;
    end
  end

  assign q     = r_q;
  assign q_bar = ~r_q;
  assign so    = r_so;
  assign z     = (r_q == '0);

endmodule

// File: tb/tb__register_univ.sv
// Bench for _register_univ: three widths (8, 2, 32) driven in lockstep, checked against
// an arithmetic reference model through an expected-value queue, plus directed spot checks.
module tb__register_univ;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic [2:0]  op;
  logic        si;
  logic [7:0]  d8;
  logic [1:0]  d2;
  logic [31:0] d32;
  logic [7:0]  q8,  qb8;
  logic [1:0]  q2,  qb2;
  logic [31:0] q32, qb32;
  logic        so8, so2, so32, z8, z2, z32;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected entry: {q32, so32, q8, so8, q2, so2}
  logic [44:0] exp_q[$];

  longint unsigned m_q8, m_q2, m_q32;
  bit              m_so8, m_so2, m_so32;

  _register_univ #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .en(en), .op(op), .d(d8), .si(si),
    .q(q8), .q_bar(qb8), .so(so8), .z(z8));
  _register_univ #(.WIDTH(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .en(en), .op(op), .d(d2), .si(si),
    .q(q2), .q_bar(qb2), .so(so2), .z(z2));
  _register_univ #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .en(en), .op(op), .d(d32), .si(si),
    .q(q32), .q_bar(qb32), .so(so32), .z(z32));

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: shifts and rotates as multiply/divide/modulo on an unsigned value.
  function automatic void model(input int w, inout longint unsigned mq, inout bit mso,
                                input logic [2:0] o, input longint unsigned dd, input bit s);
    longint unsigned modv, half, lsb, msb;
    modv = longint'(1) << w;
    half = modv / 2;
    lsb  = mq % 2;
    msb  = mq / half;
    case (o)
      3'd1: begin mq = dd % modv;                     mso = 1'b0;       end
      3'd2: begin mq = (mq * 2 + longint'(s)) % modv; mso = bit'(msb);  end
      3'd3: begin mq = mq / 2 + longint'(s) * half;   mso = bit'(lsb);  end
      3'd4: begin mq = (mq * 2) % modv + msb;         mso = bit'(msb);  end
      3'd5: begin mq = mq / 2 + lsb * half;           mso = bit'(lsb);  end
      3'd6: begin mq = mq / 2 + msb * half;           mso = bit'(lsb);  end
      3'd7: begin mq = 0;                             mso = 1'b0;       end
      default: ;
    endcase
  endfunction

  // Driver: called at a falling edge, returns at the next falling edge.
  task automatic step(input bit e, input logic [2:0] o, input logic [31:0] dd32,
                      input logic [7:0] dd8, input logic [1:0] dd2, input bit s);
    en = e; op = o; d32 = dd32; d8 = dd8; d2 = dd2; si = s;
    if (e) begin
      model(8,  m_q8,  m_so8,  o, longint'(dd8),  s);
      model(2,  m_q2,  m_so2,  o, longint'(dd2),  s);
      model(32, m_q32, m_so32, o, longint'(dd32), s);
    end
    exp_q.push_back({m_q32[31:0], m_so32, m_q8[7:0], m_so8, m_q2[1:0], m_so2});
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_q8"},   {24'd0, q8},   32'h0);
    check({tag, "_qb8"},  {24'd0, qb8},  32'hFF);
    check({tag, "_so8"},  {31'd0, so8},  32'h0);
    check({tag, "_z8"},   {31'd0, z8},   32'h1);
    check({tag, "_q2"},   {30'd0, q2},   32'h0);
    check({tag, "_qb2"},  {30'd0, qb2},  32'h3);
    check({tag, "_q32"},  q32,           32'h0);
    check({tag, "_qb32"}, qb32,          32'hFFFFFFFF);
    check({tag, "_so32"}, {31'd0, so32}, 32'h0);
  endtask

  task automatic model_reset();
    m_q8 = 0; m_q2 = 0; m_q32 = 0;
    m_so8 = 0; m_so2 = 0; m_so32 = 0;
  endtask

  // Monitor: every edge presents a result; compare it against the oldest expectation.
  initial begin
    logic [44:0] e;
    logic [31:0] eq32;
    logic [7:0]  eq8;
    logic [1:0]  eq2;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        eq32 = e[44:13];
        eq8  = e[11:4];
        eq2  = e[2:1];
        check("mon_q8",   {24'd0, q8},   {24'd0, eq8});
        check("mon_qb8",  {24'd0, qb8},  {24'd0, ~eq8});
        check("mon_so8",  {31'd0, so8},  {31'd0, e[3]});
        check("mon_z8",   {31'd0, z8},   {31'd0, eq8 == 8'd0});
        check("mon_q2",   {30'd0, q2},   {30'd0, eq2});
        check("mon_qb2",  {30'd0, qb2},  {30'd0, ~eq2});
        check("mon_so2",  {31'd0, so2},  {31'd0, e[0]});
        check("mon_z2",   {31'd0, z2},   {31'd0, eq2 == 2'd0});
        check("mon_q32",  q32,           eq32);
        check("mon_qb32", qb32,          ~eq32);
        check("mon_so32", {31'd0, so32}, {31'd0, e[12]});
        check("mon_z32",  {31'd0, z32},  {31'd0, eq32 == 32'd0});
      end
    end
  end

  initial begin
    reset_n = 1'b0; en = 1'b0; op = 3'd0; si = 1'b0;
    d8 = '0; d2 = '0; d32 = '0;
    model_reset();
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Load, complement, enable hold
    step(1, 3'd1, 32'h80000001, 8'h96, 2'b10, 0);
    check("load_q8", {24'd0, q8}, 32'h96);
    check("load_qb8", {24'd0, qb8}, 32'h69);
    check("load_z8", {31'd0, z8}, 32'h0);
    repeat (3) step(0, 3'd1, 32'h12345678, 8'h55, 2'b01, 1);
    check("en0_hold_q8", {24'd0, q8}, 32'h96);

    // Logical shifts
    step(1, 3'd2, 32'h0, 8'h0, 2'b00, 1);
    check("shl_q8", {24'd0, q8}, 32'h2D);
    check("shl_so8", {31'd0, so8}, 32'h1);
    check("shl_q32", q32, 32'h00000003);
    check("shl_q2", {30'd0, q2}, 32'h1);
    step(1, 3'd3, 32'h0, 8'h0, 2'b00, 0);
    check("shr0_q8", {24'd0, q8}, 32'h16);
    check("shr0_so8", {31'd0, so8}, 32'h1);
    step(1, 3'd3, 32'h0, 8'h0, 2'b00, 1);
    check("shr1_q8", {24'd0, q8}, 32'h8B);
    check("shr1_so8", {31'd0, so8}, 32'h0);

    // Rotates
    step(1, 3'd1, 32'h80000001, 8'h81, 2'b10, 0);
    step(1, 3'd4, 32'h0, 8'h0, 2'b00, 0);
    check("rol_q8", {24'd0, q8}, 32'h03);
    check("rol_so8", {31'd0, so8}, 32'h1);
    check("rol_q32", q32, 32'h00000003);
    check("rol_so32", {31'd0, so32}, 32'h1);
    step(1, 3'd5, 32'h0, 8'h0, 2'b00, 0);
    check("ror_q8", {24'd0, q8}, 32'h81);
    check("ror_q32", q32, 32'h80000001);
    check("ror_q2", {30'd0, q2}, 32'h2);
    step(1, 3'd1, 32'hDEADBEEF, 8'hB4, 2'b01, 0);
    repeat (8) step(1, 3'd4, 32'h0, 8'h0, 2'b00, 0);
    check("rol8_wrap_q8", {24'd0, q8}, 32'hB4);

    // Arithmetic shift saturation
    step(1, 3'd1, 32'h80000000, 8'h80, 2'b10, 0);
    step(1, 3'd6, 32'h0, 8'h0, 2'b00, 1);
    check("asr_q8", {24'd0, q8}, 32'hC0);
    check("asr_so8", {31'd0, so8}, 32'h0);
    check("asr_q2", {30'd0, q2}, 32'h3);
    check("asr_q32", q32, 32'hC0000000);
    repeat (6) step(1, 3'd6, 32'h0, 8'h0, 2'b00, 0);
    check("asr7_q8", {24'd0, q8}, 32'hFF);
    step(1, 3'd6, 32'h0, 8'h0, 2'b00, 0);
    check("asr8_q8", {24'd0, q8}, 32'hFF);
    check("asr8_so8", {31'd0, so8}, 32'h1);
    step(1, 3'd1, 32'h40000000, 8'h40, 2'b01, 0);
    step(1, 3'd6, 32'h0, 8'h0, 2'b00, 1);
    check("asr_pos_q8", {24'd0, q8}, 32'h20);

    // Clear
    step(1, 3'd1, 32'hFFFFFFFF, 8'hFF, 2'b11, 0);
    step(1, 3'd7, 32'h0, 8'h0, 2'b00, 0);
    check("clr_q8", {24'd0, q8}, 32'h0);
    check("clr_z8", {31'd0, z8}, 32'h1);
    check("clr_z32", {31'd0, z32}, 32'h1);

    // Asynchronous reset between edges, inputs ignored while asserted
    step(1, 3'd1, 32'hA5A5A5A5, 8'hA5, 2'b11, 0);
    step(1, 3'd2, 32'h0, 8'h0, 2'b00, 1);
    #2;
    reset_n = 1'b0;
    en = 1'b1; op = 3'd1; d8 = 8'hA5; d2 = 2'b11; d32 = 32'hA5A5A5A5;
    #1;
    check_reset_outputs("async");
    model_reset();
    @(negedge clk);
    check_reset_outputs("inrst");
    reset_n = 1'b1;
    step(1, 3'd1, 32'h3C3C3C3C, 8'h3C, 2'b10, 0);
    check("post_rst_load_q8", {24'd0, q8}, 32'h3C);

    // Random traffic with one reset pulse in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rand_rst");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
      end
      step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom(),
           8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    en = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
